// File: rtl/fmul_norm_pipe.sv
// Two-stage normalise / round / pack back end of the FP multiplier with an
// elastic valid/ready handshake and per-beat plus sticky exception flags.
module fmul_norm_pipe #(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int ZW     = 2*FRAC_W+2,
  localparam int XW     = EXP_W+2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              rm,
  input  logic                    sign,
  input  logic signed [XW-1:0]    exp_in,
  input  logic                    is_nan,
  input  logic                    is_inf,
  input  logic [FRAC_W-1:0]       inf_nan_frac,
  input  logic [ZW-1:0]           z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   s,
  output logic [2:0]              flags,
  output logic [2:0]              sticky,
  input  logic                    sticky_clr
);
  localparam int STAGES = 2;
  localparam int LW     = $clog2(ZW-1);
  localparam logic signed [XW-1:0] ZERO = '0;
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0]        ZW_X = XW'(ZW);

  typedef struct packed {
    logic              sg;
    logic [1:0]        rm;
    logic              nan;
    logic              inf;
    logic [FRAC_W-1:0] nf;
    logic [XW-1:0]     exp0;
    logic [ZW-2:0]     frac0;   // hidden bit at the MSB
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            load1, load2;
  s1_t             s1_d, s1_q;

  assign load2     = ~vld_pipe[2] | out_ready;
  assign load1     = ~vld_pipe[1] | load2;
  assign in_ready  = load1;
  assign out_valid = vld_pipe[2];

  // log2 normalising shifter: lz = leading zeros of z[ZW-2:0]
  logic [ZW-2:0] nz;
  logic [LW-1:0] lz;
  always_comb begin
    nz = z[ZW-2:0];
    lz = '0;
    for (int i = LW-1; i >= 0; i--) begin
      if ((nz >> (ZW-1-(1 << i))) == '0) begin
        nz    = nz << (1 << i);
        lz[i] = 1'b1;
      end
    end
  end

  logic signed [XW-1:0] lz_x;
  logic [XW-1:0]        rsh;
  logic                 lost;
  always_comb begin
    s1_d    = '0;
    s1_d.sg = sign;
    s1_d.rm = rm;
    s1_d.nan = is_nan;
    s1_d.inf = is_inf;
    s1_d.nf = inf_nan_frac;
    lz_x    = XW'(lz);
    rsh     = '0;
    lost    = 1'b0;
    // bits dropped by a right shift are folded into the LSB so rounding still sees them
    if (z[ZW-1]) begin
      s1_d.exp0  = exp_in + ONE;
      s1_d.frac0 = {z[ZW-1:2], z[1] | z[0]};
    end else if (exp_in > lz_x && nz[ZW-2]) begin
      s1_d.exp0  = exp_in - lz_x;
      s1_d.frac0 = nz;
    end else if (exp_in > ZERO) begin
      s1_d.frac0 = z[ZW-2:0] << (exp_in - ONE);
    end else begin
      rsh = ONE - exp_in;
      if (rsh >= ZW_X) begin
        s1_d.frac0 = (ZW-1)'(|z[ZW-2:0]);
      end else begin
        lost       = |(z[ZW-2:0] & ~({(ZW-1){1'b1}} << rsh));
        s1_d.frac0 = (z[ZW-2:0] >> rsh) | (ZW-1)'(lost);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
    end else begin
      if (load1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (load2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  logic [FRAC_W:0]      keep;
  logic [FRAC_W+1:0]    rnd;
  logic [FRAC_W-1:0]    rfrac;
  logic signed [XW-1:0] e1, rexp;
  logic                 g, r, st, inx, inc, ovf, to_inf;
  logic [EXP_W+FRAC_W:0] s_d;
  logic [2:0]           flags_d;
  always_comb begin
    e1   = s1_q.exp0;
    keep = s1_q.frac0[ZW-2 -: FRAC_W+1];
    g    = s1_q.frac0[FRAC_W-1];
    r    = s1_q.frac0[FRAC_W-2];
    st   = |s1_q.frac0[FRAC_W-3:0];
    inx  = g | r | st;
    case (s1_q.rm)
      2'b00:   inc = g & (r | st | keep[0]);
      2'b01:   inc = inx & s1_q.sg;
      2'b10:   inc = inx & ~s1_q.sg;
      default: inc = 1'b0;
    endcase
    rnd = {1'b0, keep} + (FRAC_W+2)'(inc);
    if (rnd[FRAC_W+1]) begin
      rexp  = e1 + ONE;
      rfrac = rnd[FRAC_W:1];
    end else begin
      // a denormal that rounds up into the hidden bit becomes the smallest normal
      rexp  = (e1 == ZERO && rnd[FRAC_W]) ? ONE : e1;
      rfrac = rnd[FRAC_W-1:0];
    end
    ovf = (e1 >= EMAX) || (rexp >= EMAX);
    case (s1_q.rm)
      2'b00:   to_inf = 1'b1;
      2'b01:   to_inf = s1_q.sg;
      2'b10:   to_inf = ~s1_q.sg;
      default: to_inf = 1'b0;
    endcase
    s_d     = {s1_q.sg, rexp[EXP_W-1:0], rfrac};
    flags_d = {1'b0, (rexp[EXP_W-1:0] == '0) && inx, inx};
    if (s1_q.nan) begin
      s_d     = {1'b1, {EXP_W{1'b1}}, s1_q.nf};
      flags_d = '0;
    end else if (s1_q.inf) begin
      s_d     = {s1_q.sg, {EXP_W{1'b1}}, s1_q.nf};
      flags_d = '0;
    end else if (ovf) begin
      s_d     = to_inf ? {s1_q.sg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                       : {s1_q.sg, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      flags_d = 3'b101;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s      <= '0;
      flags  <= '0;
      sticky <= '0;
    end else begin
      if (load2 && vld_pipe[1]) begin
        s     <= s_d;
        flags <= flags_d;
      end
      if (sticky_clr)                  sticky <= '0;
      else if (out_valid && out_ready) sticky <= sticky | flags;
    end
  end
endmodule

// File: doc/fmul_norm_pipe.md
# fmul_norm_pipe

Parametrised, two-stage pipelined normalise/round/pack stage for the floating-point multiplier. It takes the raw significand product, the pre-biased exponent and the special-case flags from the multiplier array stage, and produces an IEEE-754-style packed result. It adds three things to the combinational single-precision normaliser: generic exponent and fraction widths, a valid/ready elastic handshake, and per-result plus sticky exception flags for the FP status register.

## Interface
Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1, EMAX = 2^EXP_W-1.
- FRAC_W, 23, stored fraction width; ZW = 2*FRAC_W+2 product width; XW = EXP_W+2 internal exponent width (two's complement).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage 1 can accept a beat.
- rm  in  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
- sign  in  1  result sign.
- exp_in  in  XW  biased exponent of product (ea+eb-BIAS), signed.
- is_nan, is_inf  in  1 each  special-case flags from the array stage.
- inf_nan_frac  in  FRAC_W  fraction to emit for NaN/inf.
- z  in  ZW  significand product, format xx.xxxx…
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts a beat.
- s  out  1+EXP_W+FRAC_W  packed result {sign, exp, frac}.
- flags  out  3  {overflow, underflow, inexact} for the current s.
- sticky  out  3  OR of flags over all delivered beats since reset/clear.
- sticky_clr  in  1  synchronous clear of sticky.

## Operation
- Stage 1 (normalise), registered:
  - If z[ZW-1]=1: exp0 = exp_in+1, frac0 = z[ZW-1:1].
  - Otherwise, with lz = leading zeros of z[ZW-2:0] from a log2 shifter:
    - If exp_in > lz (signed) and the shifted MSB is 1: exp0 = exp_in-lz, frac0 = z<<lz.
    - Else (denormal or zero): exp0 = 0. If exp_in > 0, frac0 = z<<(exp_in-1); otherwise frac0 = z>>(1-exp_in), saturating to 0 when the shift is ≥ ZW.
  - sign, rm, is_nan, is_inf and inf_nan_frac are registered alongside.
- Stage 2 (round/pack), registered:
  - Keep 1+FRAC_W bits plus guard and round; sticky bit = OR of the remaining bits.
  - Increment rule:
    - rm=00: g&(r|st|lsb).
    - rm=01: (g|r|st)&sign.
    - rm=10: (g|r|st)&~sign.
    - rm=11: never.
  - A rounding carry-out increments the exponent. A denormal whose rounded hidden bit becomes 1 gets exponent 1.
  - ovf = exp0 ≥ EMAX or rounded exponent ≥ EMAX.
  - Priority:
    1. NaN → {1, all-ones, inf_nan_frac}.
    2. is_inf → {sign, all-ones, inf_nan_frac}.
    3. ovf → inf or max-finite ({sign, EMAX-1, all-ones}). rm=00 gives inf. rm=11 gives max. rm=01 gives inf if sign=1, else max. rm=10 gives inf if sign=0, else max.
    4. Otherwise → {sign, exp, frac}.
  - flags:
    - inexact = (g|r|st) | ovf.
    - overflow = ovf.
    - underflow = final exp field 0 & inexact.
    - NaN/inf results have all flags clear.
- sticky: updated on each out_valid&out_ready handshake with |= flags. sticky_clr clears it; when both occur in the same cycle, the clear wins and the new flags are dropped.

## Timing
- Latency is 2 cycles from the accepting edge (in_valid&in_ready) to out_valid, when unstalled. Throughput is 1 beat/cycle.
- Elastic pipeline, no bubbles:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = ~v1 | load2.
- With out_ready held low, exactly 2 beats are buffered, then in_ready=0. Beats are never dropped or duplicated, and order is preserved.
- s and flags are stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, in_ready=1 after reset release, s=0, flags=0, sticky=0. Internal valid bits are 0.
- Reset asserted mid-operation discards all in-flight beats immediately (asynchronous); sticky is cleared.
- Simultaneous accept and deliver in the same cycle are both honoured.

## Test plan
- Default params, 1.5×1.5: z=0x900000000000, exp_in=127, rm=00 → s=0x40100000 at cycle+2, flags=000.
- exp_in=0x0FE, z[47]=1, sign=0:
  - rm=00 → s=0x7F800000, flags=101.
  - rm=11 → s=0x7F7FFFFF, flags=101.
  - sign=1, rm=10 → s=0xFF7FFFFF.
- is_nan=1, inf_nan_frac=0x400000 → s=0xFFC00000, flags=000. A subsequent normal beat must not inherit NaN.
- Denormal: exp_in=−2, z=0x400000000000 (01.0…) → frac shifted right by 3, s=0x00100000, flags=000. Same with z LSB=1 → inexact=1, underflow=1, sticky accumulates 011.
- Backpressure: stream 4 beats with out_ready=0 for 5 cycles → in_ready drops after 2 accepts. On release, all 4 emerge in order with correct values.
- Assert rst while both stages are valid → out_valid=0 the same cycle, sticky=000. Next accepted beat appears 2 cycles later. sticky_clr together with a flagged handshake → sticky=000.
